fft_frame_tx: RTL
=================

FFT_FRAME_TX -- requirements
Module: fft_frame_tx

Interface
REQ-001 Parameter FRAME_LEN, default 64: samples per frame; power of two, 2..64; must equal the downstream FFT length.
REQ-002 Parameter IDLE_GAP, default 0: minimum idle cycles between the last beat of one frame and the sop beat of the next; range 0..255.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 inv  in  1  transform direction for the frame being collected, 1 = inverse.
REQ-007 abort  in  1  synchronous flush; discards the frame being collected or sent.
REQ-008 s_valid  in  1  upstream sample valid.
REQ-009 s_ready  out  1  block accepts a sample this cycle.
REQ-010 s_re  in  16  upstream sample, real part, two's complement.
REQ-011 s_im  in  16  upstream sample, imaginary part, two's complement.
REQ-012 valid_out  out  1  downstream sample valid; connects to FFT valid_in.
REQ-013 sop_out  out  1  first sample of a frame; connects to FFT sop_in.
REQ-014 inv_out  out  1  frame direction; connects to FFT inv; meaningful when sop_out=1.
REQ-015 y_re  out  16  downstream sample, real part.
REQ-016 y_im  out  16  downstream sample, imaginary part.
REQ-017 frame_cnt  out  16  count of frames fully sent; wraps 65535 -> 0.
REQ-018 busy  out  1  high in SEND or GAP.

Function
REQ-019 Buffer: FRAME_LEN x 32-bit array, {re,im}; single buffer, so collection and transmission never overlap.
REQ-020 States: FILL, SEND, GAP; reset state is FILL.
REQ-021 FILL: s_ready=1; a sample is accepted when s_valid=1 and is written at address wr_cnt, after which wr_cnt increments.
REQ-022 FILL: inv is latched into frame_inv when the sample with wr_cnt=0 is accepted; inv is ignored for all other samples.
REQ-023 FILL -> SEND on acceptance of the sample with wr_cnt=FRAME_LEN-1; wr_cnt wraps to 0 at the same time.
REQ-024 SEND: s_ready=0; one beat is issued every cycle, with no bubbles, from rd_cnt=0 to FRAME_LEN-1.
REQ-025 All downstream outputs are registered. The first beat (valid_out=1, sop_out=1, inv_out=frame_inv, data=buffer[0]) appears the cycle after FILL -> SEND.
REQ-026 Minimum latency: 1 cycle from last-sample acceptance to the sop beat.
REQ-027 sop_out is high only on the beat with rd_cnt=0; inv_out holds frame_inv for the whole frame.
REQ-028 y_re, y_im are 0 whenever valid_out=0. Data passes unmodified: no scaling, no rounding.
REQ-029 After the beat with rd_cnt=FRAME_LEN-1: frame_cnt increments by 1. The next state is GAP if IDLE_GAP>0, otherwise FILL.
REQ-030 GAP: s_ready=0 and valid_out=0 for exactly IDLE_GAP cycles, then FILL.
REQ-031 With IDLE_GAP=0 and upstream always valid, the frame period is 2*FRAME_LEN cycles.
REQ-032 abort=1 in any state, on the next edge:
- state -> FILL; wr_cnt, rd_cnt and gap counter -> 0;
- valid_out, sop_out -> 0; frame_cnt unchanged;
- a sample offered in the same cycle is not accepted, and s_ready=0 in that cycle.
REQ-033 abort takes priority over every other event in the same cycle, including completion of FILL or SEND.
REQ-034 No upstream backpressure beyond s_ready. Gaps in s_valid during FILL stall collection indefinitely without loss.

Reset
REQ-035 While rst_n=0 and after release:
- state=FILL; all counters, frame_inv and frame_cnt = 0;
- s_ready=1; valid_out=0, sop_out=0, inv_out=0, y_re=0, y_im=0, busy=0.
REQ-036 Reset asserted mid-SEND terminates the frame immediately, with no further beats. Buffer contents need not be cleared.

Verification
REQ-037 FRAME_LEN=64, IDLE_GAP=0; feed samples re=k, im=-k for k=0..63, s_valid constant, inv=1 at k=0 -> one cycle after k=63:
- 64 consecutive beats with y_re=k, y_im=-k;
- sop_out only on k=0, inv_out=1 throughout;
- then frame_cnt=1.
REQ-038 Upstream valid toggled randomly (50%) -> output frame identical to the input order with no missing or duplicated sample; s_ready=0 for exactly 64 cycles per frame.
REQ-039 inv=1 at k=0, inv=0 for k=1..63; then a second frame with inv=0 at k=0 -> frame 1 inv_out=1, frame 2 inv_out=0.
REQ-040 IDLE_GAP=5 with two back-to-back frames -> exactly 5 cycles of valid_out=0, s_ready=0 between frame 1's last beat and FILL. Frame 2's sop beat comes 1 cycle after its 64th sample.
REQ-041 abort at k=30 of FILL, then 64 new samples -> the sent frame contains only the new samples. abort at beat 10 of SEND -> valid_out=0 from the next cycle, frame_cnt unchanged, s_ready=1.
REQ-042 rst_n pulsed low asynchronously mid-SEND -> outputs go to reset values without waiting for clk, and the next frame is collected from k=0.

Source files
------------

// File: rtl/fft_frame_tx.sv
// Collects FRAME_LEN complex samples into a single buffer, then replays them as one
// gap-free FFT input frame (sop on beat 0, frame direction on inv_out).
module fft_frame_tx #(
    parameter int FRAME_LEN = 64,
    parameter int IDLE_GAP  = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inv,
    input  logic        abort,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [15:0] s_re,
    input  logic [15:0] s_im,
    output logic        valid_out,
    output logic        sop_out,
    output logic        inv_out,
    output logic [15:0] y_re,
    output logic [15:0] y_im,
    output logic [15:0] frame_cnt,
    output logic        busy,
    output logic [1:0]  state_dbg
);

    // Upstream handshake: a sample transfers on a rising edge where s_valid && s_ready.
    // s_ready is high only in FILL and drops combinationally while abort is high.
    // Downstream has no ready: a beat is consumed on every cycle valid_out is high.

    localparam int AW = $clog2(FRAME_LEN);
    localparam logic [AW-1:0] LAST     = AW'(FRAME_LEN - 1);
    localparam logic [7:0]    GAP_LAST = 8'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] wr_cnt, wr_cnt_nxt;
    logic [AW-1:0] rd_cnt, rd_cnt_nxt;
    logic [7:0]    gap_cnt, gap_cnt_nxt;
    logic          frame_inv, frame_inv_nxt;
    logic [15:0]   frame_cnt_nxt;
    logic          accept;
    logic          load_beat;
    logic          beat_sop;
    logic [AW-1:0] beat_addr;
    logic [31:0]   mem [FRAME_LEN];

    always_comb begin
        state_nxt     = state;
        wr_cnt_nxt    = wr_cnt;
        rd_cnt_nxt    = rd_cnt;
        gap_cnt_nxt   = gap_cnt;
        frame_inv_nxt = frame_inv;
        frame_cnt_nxt = frame_cnt;
        s_ready       = 1'b0;
        accept        = 1'b0;
        load_beat     = 1'b0;
        beat_sop      = 1'b0;
        beat_addr     = '0;
        if (abort) begin
            state_nxt   = FILL;
            wr_cnt_nxt  = '0;
            rd_cnt_nxt  = '0;
            gap_cnt_nxt = '0;
        end else begin
            case (state)
                FILL: begin
                    s_ready = 1'b1;
                    if (s_valid) begin
                        accept     = 1'b1;
                        wr_cnt_nxt = wr_cnt + AW'(1);
                        if (wr_cnt == '0) frame_inv_nxt = inv;
                        // Beat 0 is launched on the same edge that stores the last sample.
                        if (wr_cnt == LAST) begin
                            state_nxt  = SEND;
                            rd_cnt_nxt = '0;
                            load_beat  = 1'b1;
                            beat_sop   = 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (rd_cnt == LAST) begin
                        frame_cnt_nxt = frame_cnt + 16'd1;
                        rd_cnt_nxt    = '0;
                        gap_cnt_nxt   = '0;
                        state_nxt     = (IDLE_GAP > 0) ? GAP : FILL;
                    end else begin
                        rd_cnt_nxt = rd_cnt + AW'(1);
                        load_beat  = 1'b1;
                        beat_addr  = rd_cnt + AW'(1);
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state_nxt   = FILL;
                        gap_cnt_nxt = '0;
                    end else begin
                        gap_cnt_nxt = gap_cnt + 8'd1;
                    end
                end
                default: state_nxt = FILL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            gap_cnt   <= '0;
            frame_inv <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state     <= state_nxt;
            wr_cnt    <= wr_cnt_nxt;
            rd_cnt    <= rd_cnt_nxt;
            gap_cnt   <= gap_cnt_nxt;
            frame_inv <= frame_inv_nxt;
            frame_cnt <= frame_cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) mem[wr_cnt] <= {s_re, s_im};
    end

    // Output stage is zero on every cycle that does not carry a beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out <= 1'b0;
            sop_out   <= 1'b0;
            inv_out   <= 1'b0;
            y_re      <= '0;
            y_im      <= '0;
        end else if (load_beat) begin
            valid_out <= 1'b1;
            sop_out   <= beat_sop;
            inv_out   <= frame_inv_nxt;
            y_re      <= mem[beat_addr][31:16];
            y_im      <= mem[beat_addr][15:0];
        end else begin
            valid_out <= 1'b0;
            sop_out   <= 1'b0;
            inv_out   <= 1'b0;
            y_re      <= '0;
            y_im      <= '0;
        end
    end

    assign busy      = (state != FILL);
    assign state_dbg = state;

endmodule
